// File: rtl/iob_bitrev_reorder.sv
// iob_bitrev_reorder: collects a frame of N = 2^ADDR_W words in natural order,
// then replays it in bit-reversed index order (e.g. for radix-2 FFT reordering).
//
// Handshake: a transfer happens on a rising edge where valid, ready and cke_i
// are all high. Ready never depends on valid. Output data and last remain
// stable while out_valid_o is high and out_ready_i is low. Input and output
// phases never overlap: FILL accepts words, DRAIN emits them.
module iob_bitrev_reorder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              dbg_state_o
);

    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem_q [N];
    logic                in_fire;
    logic                out_fire;
    logic                mem_we;

    // Bit-reverse the read counter to form the array read address.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            rd_addr[i] = rd_cnt_q[ADDR_W-1-i];
        end
    end

    // Phase outputs, transfer detection and next-state/counter logic.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;

        if (state_q == S_FILL) begin
            in_ready_o = 1'b1;
        end else begin
            out_valid_o = 1'b1;
            out_last_o  = (rd_cnt_q == LAST_IDX);
        end

        in_fire  = in_valid_i & in_ready_o & cke_i;
        out_fire = out_valid_o & out_ready_i & cke_i;
        // Flush discards the frame, so a simultaneous input word is dropped.
        mem_we   = in_fire & ~flush_i;

        if (flush_i && cke_i) begin
            state_d  = S_FILL;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end else if (in_fire) begin
            // Counter wraps to 0 naturally since N is a power of two.
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            if (wr_cnt_q == LAST_IDX) begin
                state_d = S_DRAIN;
            end
        end else if (out_fire) begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            if (rd_cnt_q == LAST_IDX) begin
                state_d = S_FILL;
            end
        end
    end

    // FSM state and counters; hold everything while cke_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Frame storage: cleared by reset, retained across flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wr_cnt_q] <= in_data_i;
        end
    end

    assign out_data_o  = mem_q[rd_addr];
    assign busy_o      = (state_q == S_DRAIN) || (wr_cnt_q != '0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_bitrev_reorder.sv
// Bench for iob_bitrev_reorder (ADDR_W=3, DATA_W=8): directed frames plus
// random traffic, checked by a frame-level reference model and scoreboard.
module tb_iob_bitrev_reorder;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int N      = 8;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst;
    logic              cke;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    iob_bitrev_reorder #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cke_i      (cke),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_ready_i(out_ready),
        .busy_o     (busy),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    int                out_cnt  = 0;
    bit                bp_mode  = 1'b0;
    logic [DATA_W:0]   exp_q[$];      // {last, data} in expected output order
    logic [DATA_W-1:0] frame_q[$];    // words of the frame being collected

    // Reverse the low ADDR_W bits of an index by repeated halving.
    function automatic int rev_idx(input int i);
        int r;
        int x;
        r = 0;
        x = i;
        for (int k = 0; k < ADDR_W; k++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- monitor / reference model ----------------
    // Mid-cycle: compare DUT outputs against the model, then apply the
    // effect of the upcoming edge to the model.
    always @(negedge clk) begin
        bit filling;
        filling = (exp_q.size() == 0);
        check("in_ready",  {31'b0, in_ready},  {31'b0, filling});
        check("out_valid", {31'b0, out_valid}, {31'b0, !filling});
        check("busy",      {31'b0, busy},      {31'b0, (!filling || frame_q.size() > 0)});
        if (!filling) begin
            check("out_data", {24'b0, out_data}, {24'b0, exp_q[0][DATA_W-1:0]});
            check("out_last", {31'b0, out_last}, {31'b0, exp_q[0][DATA_W]});
        end
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
        end else if (cke) begin
            if (flush) begin
                frame_q.delete();
                exp_q.delete();
            end else if (filling && in_valid) begin
                frame_q.push_back(in_data);
                if (frame_q.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        exp_q.push_back({(k == N - 1), frame_q[rev_idx(k)]});
                    end
                    frame_q.delete();
                end
            end else if (!filling && out_ready) begin
                void'(exp_q.pop_front());
                out_cnt++;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready && cke && !flush;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) timeout_fail("push_word");
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] base, input bit rnd);
        for (int k = 0; k < N; k++) begin
            push_word(rnd ? DATA_W'($urandom) : DATA_W'(base + k));
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk);
            done = (exp_q.size() == 0);
        end
        #1;
        if (!done) timeout_fail("wait_drain");
    endtask

    task automatic wait_out(input int target);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk);
            done = (out_cnt >= target);
        end
        #1;
        if (!done) timeout_fail("wait_out");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst      = 1'b1;
        cke      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last",  {31'b0, out_last},  32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_data",  {24'b0, out_data},  32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Ascending frame, both sides always ready.
        base = out_cnt;
        send_frame(8'h00, 1'b0);
        wait_drain();
        check("frame0_count", out_cnt - base, N);

        // Three back-to-back random frames under random back-pressure.
        bp_mode = 1'b1;
        base = out_cnt;
        repeat (3) send_frame(8'h00, 1'b1);
        wait_drain();
        check("bp_count", out_cnt - base, 3 * N);
        bp_mode = 1'b0;

        // Flush after 5 inputs, then a fresh frame.
        for (int k = 0; k < 5; k++) push_word(8'hA0 + 8'(k));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        base = out_cnt;
        send_frame(8'h10, 1'b0);
        wait_drain();
        check("flush_count", out_cnt - base, N);

        // Reset after 3 drained outputs.
        send_frame(8'h30, 1'b0);
        wait_out(out_cnt + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_data",  {24'b0, out_data},  32'd0);
        tick();
        base = out_cnt;
        send_frame(8'h00, 1'b1);
        wait_drain();
        check("postrst_count", out_cnt - base, N);

        // Clock enable low for 4 cycles mid-drain.
        send_frame(8'h50, 1'b0);
        wait_out(out_cnt + 2);
        cke = 1'b0;
        repeat (4) tick();
        cke = 1'b1;
        wait_drain();

        // Random traffic: valid, data, cke, occasional flush, back-pressure.
        bp_mode = 1'b1;
        repeat (400) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DATA_W'($urandom);
            cke      = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 60) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        cke      = 1'b1;
        wait_drain();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bp_mode = 1'b0;
        repeat (3) tick();

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_bitrev_reorder.md
IOB_BITREV_REORDER -- requirements
Module: iob_bitrev_reorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning log2 of the frame length; N = 2^ADDR_W words per frame; legal range 1..10.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cke_i, input, 1 bit: clock enable; when low, all state holds.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous abort of the current frame.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: input word valid.
REQ-008 The block SHALL have port in_data_i, input, DATA_W bits: input word.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: block accepts an input word.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: output word valid.
REQ-011 The block SHALL have port out_data_o, output, DATA_W bits: output word.
REQ-012 The block SHALL have port out_last_o, output, 1 bit: marks the final word of a frame.
REQ-013 The block SHALL have port out_ready_i, input, 1 bit: consumer accepts the output word.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high while the block is in DRAIN or has accepted at least one word of the current frame.

Function
REQ-015 The block SHALL hold an N x DATA_W register array, write counter wr_cnt (ADDR_W bits), read counter rd_cnt (ADDR_W bits) and a 2-state FSM: FILL, DRAIN.
REQ-016 In FILL, in_ready_o SHALL be 1, out_valid_o 0, out_last_o 0.
REQ-017 In FILL, an input transfer (in_valid_i & in_ready_o & cke_i) SHALL write in_data_i to mem[wr_cnt] and increment wr_cnt.
REQ-018 A transfer with wr_cnt == N-1 SHALL set wr_cnt to 0 and move the FSM to DRAIN on the same edge.
REQ-019 In DRAIN, in_ready_o SHALL be 0, out_valid_o 1, and out_data_o SHALL equal mem[rev(rd_cnt)], where rev(x) bit i = x bit (ADDR_W-1-i); out_data_o is combinational from the register array.
REQ-020 In DRAIN, out_last_o SHALL be 1 exactly when rd_cnt == N-1.
REQ-021 An output transfer (out_valid_o & out_ready_i & cke_i) SHALL increment rd_cnt; with rd_cnt == N-1 it SHALL set rd_cnt to 0 and move the FSM to FILL.
REQ-022 With out_ready_i low in DRAIN, out_data_o and out_last_o SHALL stay stable.
REQ-023 Latency: the first output word SHALL be valid in the cycle after the edge that accepts the N-th input word.
REQ-024 Sustained throughput SHALL be one word per cycle in each phase; a full frame round trip with both sides always ready takes 2N cycles.
REQ-025 Inputs and outputs SHALL never transfer in the same cycle; no overlap between frames.
REQ-026 flush_i high with cke_i high SHALL force FILL, wr_cnt = 0 and rd_cnt = 0 on that edge, overriding any concurrent transfer; array contents are retained.
REQ-027 When cke_i is low, the FSM, counters and array SHALL hold; outputs continue to reflect the held state.
REQ-028 ADDR_W == 1 SHALL be supported, with rev as the identity and output order 0,1.

Reset
REQ-029 rst_i SHALL take priority over flush_i and cke_i; when high on a rising edge, the FSM SHALL enter FILL and wr_cnt, rd_cnt and all array entries SHALL clear to 0.
REQ-030 After reset: in_ready_o = 1, out_valid_o = 0, out_last_o = 0, busy_o = 0, out_data_o = 0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL discard the frame; no partial output follows.

Verification (ADDR_W = 3, DATA_W = 8)
REQ-032 Inputs 0x00..0x07, both sides always ready -> outputs 0x00,0x04,0x02,0x06,0x01,0x05,0x03,0x07 on 8 consecutive cycles starting 1 cycle after the 8th input; out_last_o only on 0x07.
REQ-033 Random out_ready_i back-pressure over 3 back-to-back frames -> order per REQ-032 in each frame, no duplication or loss, in_ready_o = 0 throughout every DRAIN.
REQ-034 flush_i after 5 inputs, then inputs 0x10..0x17 -> outputs 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
REQ-035 rst_i asserted after 3 drained outputs -> next cycle in_ready_o = 1, out_valid_o = 0; the next frame drains correctly.
REQ-036 cke_i low for 4 cycles mid-DRAIN with out_ready_i = 1 -> no rd_cnt advance; out_data_o holds; the sequence resumes unchanged.
